pong_ball_ctrl: RTL
===================

Name: pong_ball_ctrl

Overview:
- Game-logic stage directly upstream of the Pong VGA renderer.
- On every end-of-frame animate pulse it moves the ball, bounces it off walls and paddles, and detects misses.
- Keeps both players' scores and runs a serve/play/game-over state machine.
- Outputs the ball bounding box (x1/x2/y1/y2, 12-bit) that the renderer's rectangle compare consumes.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_HALF, 10, half of the ball side; box = centre ± BALL_HALF
- HSPEED, 2, horizontal pixels per frame
- VSPEED, 2, vertical pixels per frame
- LEFT_FACE_X, 20, x of left paddle's inner face
- RIGHT_FACE_X, 620, x of right paddle's inner face
- WIN_SCORE, 9, score that ends the game
- SERVE_FRAMES, 60, animate pulses spent in SERVE before play
- MAX_SPEED, 6, horizontal speed cap (used only with SPEEDUP_EN)

Ports:
- in_clock  in  1  system clock, 50 MHz
- in_reset  in  1  asynchronous, active-low reset
- in_animate  in  1  one-cycle pulse at end of visible frame
- in_start  in  1  level; start a game from IDLE or GAME_OVER
- in_lpad_y1  in  12  left paddle top
- in_lpad_y2  in  12  left paddle bottom
- in_rpad_y1  in  12  right paddle top
- in_rpad_y2  in  12  right paddle bottom
- out_x1  out  12  ball box left
- out_x2  out  12  ball box right
- out_y1  out  12  ball box top
- out_y2  out  12  ball box bottom
- out_score_l  out  4  left player score, 0..WIN_SCORE
- out_score_r  out  4  right player score, 0..WIN_SCORE
- out_point  out  1  one-cycle pulse when a point is scored
- out_game_over  out  1  high while in GAME_OVER
- out_state  out  2  current FSM state, for debug

Behaviour:
- Reset values (asynchronous, in_reset low):
  - state = IDLE
  - ball centre = (SCREEN_W/2, SCREEN_H/2), so the box is 310/330/230/250 at defaults
  - dx = +1 (right), dy = +1 (down), speed = HSPEED
  - scores = 0, out_point = 0, out_game_over = 0, serve counter = 0
- Outputs are registered; box coordinates are derived from the centre registers, with no extra latency.
- FSM encoding: IDLE = 0, SERVE = 1, PLAY = 2, GAME_OVER = 3.
- IDLE:
  - Ball held at centre.
  - in_start = 1 → SERVE, serve counter cleared.
- SERVE:
  - Ball held at centre.
  - Counter increments on each in_animate.
  - On the pulse where counter = SERVE_FRAMES-1 → PLAY.
- PLAY: only on cycles with in_animate = 1, the next centre is computed from the current centre ± speed (dx) and ± VSPEED (dy). Rules are evaluated in this order:
  1. Top/bottom walls:
     - if dy down and cy+BALL_HALF+VSPEED ≥ SCREEN_H: dy flips, cy clamps to SCREEN_H-BALL_HALF
     - if dy up and cy < BALL_HALF+VSPEED: dy flips, cy clamps to BALL_HALF
  2. Paddle hit: moving left, next x1 ≤ LEFT_FACE_X, and y-overlap (cy+BALL_HALF > in_lpad_y1 and cy-BALL_HALF < in_lpad_y2):
     - dx flips, cx clamps to LEFT_FACE_X+BALL_HALF
     - mirror rule for the right paddle using next x2 ≥ RIGHT_FACE_X
  3. Miss: moving left, cx < BALL_HALF+speed, and no paddle hit:
     - right score +1, out_point pulses, dx set to -1 (serve toward the scorer's opponent)
     - mirror for the right edge (SCREEN_W)
  - A wall bounce and a paddle hit in the same frame both apply.
  - Nothing is ever added that would wrap 12-bit arithmetic; underflow is prevented by the compare-before-subtract rules above.
- After a point:
  - Ball recentred, dy keeps its value.
  - If the new score = WIN_SCORE → GAME_OVER, otherwise → SERVE.
  - The state change happens on the same clock edge as the score update.
- GAME_OVER:
  - out_game_over = 1, ball held at centre, scores frozen.
  - in_start = 1 → scores cleared, → SERVE.
- Outside PLAY, in_animate is ignored (except the serve count).
- Reset mid-operation returns to the reset values immediately.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined: each paddle hit adds 1 to speed, saturating at MAX_SPEED; speed returns to HSPEED on every entry to SERVE.
- Undefined: speed is constant at HSPEED and no speed register is instantiated.

Decomposition:
- Package pong_pkg holds:
  - the state encoding constants
  - the screen-size constants
  - the coordinate width (12)
- One sub-module, pong_score_counter:
  - 4-bit counter with synchronous clear, increment enable, and a win flag when the count equals WIN_SCORE
  - instantiated twice, once per player

Test Plan:
- Reset low, then high → box 310/330/230/250, scores 0, state IDLE; in_animate pulses do not move the ball.
- in_start = 1 for one cycle, then 60 in_animate pulses → state reaches PLAY exactly on pulse 60; the next pulse moves the box to x1 = 312, y1 = 232.
- Ball placed near the bottom, moving down (cy = 469, dy down) → after one pulse cy = 470 (box y2 = 480), dy up; the next pulse gives cy = 468.
- Left paddle at y 200..380, ball moving left at cy = 240 reaching the face → dx flips, x1 = 20, no point. Move the paddle to 0..100 → out_point pulses once, score_r goes 0 → 1, ball recentred, state SERVE.
- Force score_l to 8, then a right-side miss → score_l = 9, out_game_over = 1, state GAME_OVER; in_start → scores 0, state SERVE.
- With PONG_SPEEDUP_EN defined: 5 consecutive paddle hits → speed 3, 4, 5, 6, 6; after a point, speed is 2 again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong game-logic block.
//   COORD_W / SCORE_W : coordinate and score widths
//   SCREEN_W/SCREEN_H : visible area in pixels
//   MAX_SPEED         : horizontal speed cap for the optional speed-up build
//   state_e           : game FSM encoding (IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3)
package pong_pkg;

    localparam int unsigned COORD_W   = 12;
    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned MAX_SPEED = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE     = 2'd1,
        ST_PLAY      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

endpackage

// File: rtl/pong_score_counter.sv
// Per-player score counter.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (has priority over inc_i)
//   inc_i      : add one to the score
//   count_o    : current score
//   win_o      : high while the score equals WIN_SCORE
module pong_score_counter
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [SCORE_W-1:0] count_o,
    output logic               win_o
);

    logic [SCORE_W-1:0] count_q, count_d;
    logic               win_q;

    // Next count
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + SCORE_W'(1);
        end
    end

    // Win flag is registered alongside the count so both change together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            win_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            win_q   <= (count_d == SCORE_W'(WIN_SCORE));
        end
    end

    assign count_o = count_q;
    assign win_o   = win_q;

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong ball motion, collision, scoring and serve/play/game-over control.
// Updates once per in_animate pulse (end of visible frame) and feeds the
// ball bounding box to the VGA renderer.
//   in_clock, in_reset          : clock, async active-low reset
//   in_animate                  : one-cycle end-of-frame pulse
//   in_start                    : start a game from IDLE or GAME_OVER
//   in_lpad_y1/y2, in_rpad_y1/y2: paddle vertical extents
//   out_x1/x2/y1/y2             : ball box, derived from the centre registers
//   out_score_l/r               : player scores
//   out_point                   : one-cycle pulse when a point is scored
//   out_game_over               : high while in GAME_OVER
//   out_state                   : FSM state for debug
// Optional feature macro: PONG_SPEEDUP_EN (paddle hits speed the ball up
// to MAX_SPEED; speed returns to HSPEED on every entry to SERVE).
module pong_ball_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALL_HALF    = 10,
    parameter int unsigned HSPEED       = 2,
    parameter int unsigned VSPEED       = 2,
    parameter int unsigned LEFT_FACE_X  = 20,
    parameter int unsigned RIGHT_FACE_X = 620,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_animate,
    input  logic               in_start,
    input  logic [COORD_W-1:0] in_lpad_y1,
    input  logic [COORD_W-1:0] in_lpad_y2,
    input  logic [COORD_W-1:0] in_rpad_y1,
    input  logic [COORD_W-1:0] in_rpad_y2,
    output logic [COORD_W-1:0] out_x1,
    output logic [COORD_W-1:0] out_x2,
    output logic [COORD_W-1:0] out_y1,
    output logic [COORD_W-1:0] out_y2,
    output logic [SCORE_W-1:0] out_score_l,
    output logic [SCORE_W-1:0] out_score_r,
    output logic               out_point,
    output logic               out_game_over,
    output logic [1:0]         out_state
);

    localparam int unsigned SERVE_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [COORD_W-1:0] C_CX0    = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] C_CY0    = COORD_W'(SCREEN_H / 2);
    localparam logic [COORD_W-1:0] C_W      = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] C_H      = COORD_W'(SCREEN_H);
    localparam logic [COORD_W-1:0] C_BH     = COORD_W'(BALL_HALF);
    localparam logic [COORD_W-1:0] C_HSPEED = COORD_W'(HSPEED);
    localparam logic [COORD_W-1:0] C_VSPEED = COORD_W'(VSPEED);
    localparam logic [COORD_W-1:0] C_LFACE  = COORD_W'(LEFT_FACE_X);
    localparam logic [COORD_W-1:0] C_RFACE  = COORD_W'(RIGHT_FACE_X);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic                 dx_q, dx_d;   // 1 = moving right
    logic                 dy_q, dy_d;   // 1 = moving down
    logic [SERVE_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic                 point_q, point_d;
    logic                 game_over_q;
    logic [COORD_W-1:0]   speed;
    logic                 hit, miss_l, miss_r, clr_scores;
    logic                 ovl_l, ovl_r;
    logic                 win_l, win_r;
    logic [SCORE_W-1:0]   score_l, score_r;

    // Vertical overlap of the ball with each paddle (cy >= BALL_HALF always holds)
    assign ovl_l = (cy_q + C_BH > in_lpad_y1) && (cy_q - C_BH < in_lpad_y2);
    assign ovl_r = (cy_q + C_BH > in_rpad_y1) && (cy_q - C_BH < in_rpad_y2);

`ifdef PONG_SPEEDUP_EN
    logic [COORD_W-1:0] speed_q, speed_d;

    // Speed-up on paddle hits, restored on each entry to SERVE
    always_comb begin
        speed_d = speed_q;
        if (state_d == ST_SERVE && state_q != ST_SERVE) begin
            speed_d = C_HSPEED;
        end else if (hit && speed_q < COORD_W'(MAX_SPEED)) begin
            speed_d = speed_q + COORD_W'(1);
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            speed_q <= C_HSPEED;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed = speed_q;
`else
    assign speed = C_HSPEED;
`endif

    // Next-state, ball motion and scoring decisions
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_cnt_d = serve_cnt_q;
        point_d     = 1'b0;
        hit         = 1'b0;
        miss_l      = 1'b0;
        miss_r      = 1'b0;
        clr_scores  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cx_d = C_CX0;
                cy_d = C_CY0;
                if (in_start) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = '0;
                    clr_scores  = 1'b1;
                end
            end

            ST_SERVE: begin
                cx_d = C_CX0;
                cy_d = C_CY0;
                if (in_animate) begin
                    serve_cnt_d = serve_cnt_q + SERVE_W'(1);
                    if (serve_cnt_q == SERVE_W'(SERVE_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                    end
                end
            end

            ST_PLAY: begin
                if (in_animate) begin
                    // Top/bottom walls; compares are arranged so nothing underflows
                    if (dy_q) begin
                        if (cy_q + C_BH + C_VSPEED >= C_H) begin
                            dy_d = 1'b0;
                            cy_d = C_H - C_BH;
                        end else begin
                            cy_d = cy_q + C_VSPEED;
                        end
                    end else begin
                        if (cy_q < C_BH + C_VSPEED) begin
                            dy_d = 1'b1;
                            cy_d = C_BH;
                        end else begin
                            cy_d = cy_q - C_VSPEED;
                        end
                    end

                    // Paddle faces, then screen-edge misses
                    if (!dx_q) begin
                        if ((cx_q <= C_LFACE + C_BH + speed) && ovl_l) begin
                            hit  = 1'b1;
                            dx_d = 1'b1;
                            cx_d = C_LFACE + C_BH;
                        end else if (cx_q < C_BH + speed) begin
                            miss_l = 1'b1;
                        end else begin
                            cx_d = cx_q - speed;
                        end
                    end else begin
                        if ((cx_q + speed + C_BH >= C_RFACE) && ovl_r) begin
                            hit  = 1'b1;
                            dx_d = 1'b0;
                            cx_d = C_RFACE - C_BH;
                        end else if (cx_q + speed + C_BH > C_W) begin
                            miss_r = 1'b1;
                        end else begin
                            cx_d = cx_q + speed;
                        end
                    end

                    // Point: recentre, serve away from the scorer
                    if (miss_l || miss_r) begin
                        cx_d        = C_CX0;
                        cy_d        = C_CY0;
                        dy_d        = dy_q;
                        dx_d        = miss_r;
                        point_d     = 1'b1;
                        serve_cnt_d = '0;
                        if ((miss_l && score_r == SCORE_W'(WIN_SCORE - 1)) ||
                            (miss_r && score_l == SCORE_W'(WIN_SCORE - 1))) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end
                end
            end

            ST_GAME_OVER: begin
                cx_d = C_CX0;
                cy_d = C_CY0;
                if (in_start) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = '0;
                    clr_scores  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and ball registers
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= ST_IDLE;
            cx_q        <= C_CX0;
            cy_q        <= C_CY0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_cnt_q <= '0;
            point_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_cnt_q <= serve_cnt_d;
            point_q     <= point_d;
            game_over_q <= (state_d == ST_GAME_OVER);
        end
    end

    // A miss by the left player scores for the right player and vice versa
    pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_l (
        .clk     (in_clock),
        .rst_n   (in_reset),
        .clr_i   (clr_scores),
        .inc_i   (miss_r && !win_l),
        .count_o (score_l),
        .win_o   (win_l)
    );

    pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_r (
        .clk     (in_clock),
        .rst_n   (in_reset),
        .clr_i   (clr_scores),
        .inc_i   (miss_l && !win_r),
        .count_o (score_r),
        .win_o   (win_r)
    );

    assign out_x1        = cx_q - C_BH;
    assign out_x2        = cx_q + C_BH;
    assign out_y1        = cy_q - C_BH;
    assign out_y2        = cy_q + C_BH;
    assign out_score_l   = score_l;
    assign out_score_r   = score_r;
    assign out_point     = point_q;
    assign out_game_over = game_over_q;
    assign out_state     = state_q;

endmodule
